imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational `imem` (word-addressed; addr[1:0] ignored).
- Owns the program counter and drives `imem_addr`.
- Captures each returned instruction, together with its PC, into a small FIFO.
- Presents FIFO contents to decode over a valid/ready handshake.
- Handles run/halt control and PC redirects (branch/jump/trap) with a FIFO flush.
- Sits between `imem` and the decode stage of the core.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 0.
FIFO_DEPTH, 2, entries in the instruction buffer; power of two, ≥2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
fetch_en  input  1  1 = fetch; 0 = stop issuing new fetches
redirect_valid  input  1  load new PC and flush buffer this cycle
redirect_pc  input  32  redirect target; bits [1:0] ignored
imem_addr  output  32  address to imem; equals pc_q, bits [1:0] always 0
imem_instr  input  32  instruction from imem for imem_addr, same cycle (combinational)
inst_valid  output  1  FIFO head is valid
inst_ready  input  1  decode accepts head this cycle
inst_data  output  32  instruction at FIFO head
inst_pc  output  32  PC of instruction at FIFO head
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n=0 at edge):
  - pc_q=RESET_PC & ~3; FIFO empty; state=IDLE.
  - inst_valid=0, inst_data=0, inst_pc=0, busy=0, imem_addr=RESET_PC & ~3.
  - Reset mid-operation discards all buffered entries and any pending redirect.
- FIFO holds {pc, instr} pairs.
  - Outputs are driven from registered storage; inst_data/inst_pc read 0 when empty.
  - pop = inst_valid & inst_ready.
  - push_ok = !full | pop: push into a full FIFO is allowed when a pop happens in the same cycle.
  - count never exceeds FIFO_DEPTH or underflows.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: no push. fetch_en=1 → FETCH.
  - FETCH: push {pc_q, imem_instr} when push_ok, then pc_q += 4. fetch_en=0 → DRAIN.
  - DRAIN: no push. FIFO empty → IDLE. fetch_en=1 → FETCH.
- Latency: a push in cycle N makes that entry visible on inst_valid/inst_data in cycle N+1. The first instruction appears 2 cycles after fetch_en is sampled high from IDLE (transition cycle, push cycle).
- Throughput: sustained 1 instruction/cycle while inst_ready=1.
- Stall: when the FIFO is full and there is no pop, pc_q holds and no push occurs. imem_addr stays stable.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 → 0x0000_0000, with no error flag.
- Redirect (highest priority, any state except reset):
  - FIFO flushed (count=0), no push that cycle, any pop that cycle ignored.
  - pc_q = {redirect_pc[31:2], 2'b00}.
  - State: FETCH if fetch_en=1, else IDLE.
  - inst_valid=0 in the following cycle. The first new-target instruction is valid 2 cycles after redirect.
- Simultaneous redirect and fetch_en falling: redirect wins, state goes to IDLE, FIFO is empty.
- inst_valid, once high, holds inst_data/inst_pc stable until popped or flushed (redirect/reset).
- busy = (state != IDLE) | (count != 0).

Test Plan:
1. Reset then fetch_en=1, inst_ready=1 (imem: 0x0→0x00500093, 0x4→0x00600113, 0x8→0x002081b3, 0xC→0x403101b3, 0x10→0x00000013)
   → inst_valid rises 2 cycles after fetch_en.
   → {pc,data} = (0,00500093), (4,00600113), (8,002081b3), (C,403101b3), (10,00000013) on consecutive cycles.
2. Back-pressure: inst_ready=0 for 5 cycles after first valid
   → FIFO fills to 2; imem_addr frozen at 0x8.
   → head stays (0,00500093).
   → after release, order continues without loss or duplicates.
3. Redirect with redirect_pc=0x0000_0005 while FIFO holds 2 entries
   → next cycle inst_valid=0.
   → then (4,00600113), then (8,002081b3).
4. fetch_en dropped with 2 buffered, inst_ready=1
   → both entries drain; state goes DRAIN→IDLE; busy falls after the last pop; imem_addr holds.
5. Reset asserted mid-stream with FIFO full
   → next cycle inst_valid=0, busy=0, imem_addr=0x0.
   → on re-enable, first output is (0,00500093).
6. Redirect to 0xFFFF_FFFC
   → entries with pc 0xFFFFFFFC, then 0x00000000 (data 00500093).

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-fetch sequencer sitting between a combinational, word-addressed
// instruction memory and the decode stage. It owns the program counter,
// captures {pc, instr} pairs into a small FIFO and hands them to decode over
// a valid/ready handshake. Redirects (branch/jump/trap) reload the PC and
// flush the buffer.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst_n           synchronous active-low reset
//   fetch_en        1 = issue fetches, 0 = stop issuing new fetches
//   redirect_valid  load redirect_pc and flush the buffer this cycle
//   redirect_pc     redirect target (bits [1:0] ignored)
//   imem_addr       address to imem (the current PC, word aligned)
//   imem_instr      instruction returned by imem for imem_addr, same cycle
//   inst_valid      FIFO head is valid
//   inst_ready      decode accepts the head this cycle
//   inst_data       instruction at the FIFO head (0 when empty)
//   inst_pc         PC of the instruction at the FIFO head (0 when empty)
//   busy            FSM not idle or FIFO not empty
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state;
  logic [31:0]      pc_q;
  logic [31:0]      mem_pc    [FIFO_DEPTH];
  logic [31:0]      mem_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  // A redirect flushes the buffer, so neither a pop nor a push may take
  // effect in that cycle.
  assign pop     = !empty && inst_ready && !redirect_valid;
  assign push_ok = !full || pop;
  assign push    = (state == FETCH) && fetch_en && push_ok && !redirect_valid;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Buffer storage has no reset: entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc_q;
      mem_instr[wr_ptr] <= imem_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_q   <= RESET_PC & ~32'h3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc & ~32'h3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= fetch_en ? FETCH : IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc_q   <= pc_q + 32'd4;   // wraps modulo 2^32
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      case (state)
        IDLE:    if (fetch_en) state <= FETCH;
        FETCH:   if (!fetch_en) state <= DRAIN;
        DRAIN: begin
          if (fetch_en)
            state <= FETCH;
          else if (count_next == '0)
            state <= IDLE;   // leave as soon as the last entry is taken
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = !empty;
  assign inst_data  = empty ? 32'h0 : mem_instr[rd_ptr];
  assign inst_pc    = empty ? 32'h0 : mem_pc[rd_ptr];
  assign busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: program table plus a recognisable filler.
  function automatic logic [31:0] imem_model(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0060_0113;
      32'h0000_0008: return 32'h0020_81b3;
      32'h0000_000C: return 32'h4031_01b3;
      32'h0000_0010: return 32'h0000_0013;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_instr = imem_model(imem_addr);

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b data=%h pc=%h addr=%h, want 0 0 0 0 0",
               inst_valid, busy, inst_data, inst_pc, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL idle_hold: valid=%b busy=%b addr=%h, want 0 0 0", inst_valid, busy, imem_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [5];
    logic [31:0] exp_d  [5];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_d  = '{32'h0050_0093, 32'h0060_0113, 32'h0020_81b3, 32'h4031_01b3, 32'h0000_0013};
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    step();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency: valid=%b one cycle after enable, want 0", inst_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst_data !== exp_d[i]) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b pc=%h data=%h, want 1 %h %h",
                 i, inst_valid, inst_pc, inst_data, exp_pc[i], exp_d[i]);
      end
      $display("stream beat %0d pc=%h data=%h", i, inst_pc, inst_data);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [4];
    logic [31:0] exp_d  [4];
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    exp_d  = '{32'h0060_0113, 32'h0020_81b3, 32'h4031_01b3, 32'h0000_0013};
    do_reset();
    fetch_en = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0050_0093) begin
        errors++;
        $display("FAIL bp_head_%0d: valid=%b pc=%h data=%h, want 1 00000000 00500093",
                 i, inst_valid, inst_pc, inst_data);
      end
      step();
      if (i > 0) begin
        checks++;
        if (imem_addr !== 32'h8) begin
          errors++;
          $display("FAIL bp_addr_%0d: addr=%h, want 00000008", i, imem_addr);
        end
      end
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst_data !== exp_d[i]) begin
        errors++;
        $display("FAIL bp_release_%0d: valid=%b pc=%h data=%h, want 1 %h %h",
                 i, inst_valid, inst_pc, inst_data, exp_pc[i], exp_d[i]);
      end
      $display("release beat %0d pc=%h data=%h", i, inst_pc, inst_data);
    end
  endtask

  task automatic fill_two();
    do_reset();
    fetch_en = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic test_redirect();
    fill_two();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0005;
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL redir_flush: valid=%b addr=%h, want 0 00000004", inst_valid, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h0060_0113) begin
      errors++;
      $display("FAIL redir_first: valid=%b pc=%h data=%h, want 1 00000004 00600113", inst_valid, inst_pc, inst_data);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'h0020_81b3) begin
      errors++;
      $display("FAIL redir_second: valid=%b pc=%h data=%h, want 1 00000008 002081b3", inst_valid, inst_pc, inst_data);
    end
    $display("test_redirect done");
  endtask

  task automatic test_drain();
    fill_two();
    fetch_en = 1'b0;
    inst_ready = 1'b1;
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || busy !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL drain_one: valid=%b pc=%h busy=%b addr=%h, want 1 00000004 1 00000008",
               inst_valid, inst_pc, busy, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL drain_done: valid=%b busy=%b addr=%h, want 0 0 00000008", inst_valid, busy, imem_addr);
    end
    $display("test_drain done");
  endtask

  task automatic test_reset_midstream();
    fill_two();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midreset: valid=%b busy=%b addr=%h, want 0 0 00000000", inst_valid, busy, imem_addr);
    end
    inst_ready = 1'b1;
    step();
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0050_0093) begin
      errors++;
      $display("FAIL midreset_restart: valid=%b pc=%h data=%h, want 1 00000000 00500093", inst_valid, inst_pc, inst_data);
    end
    $display("test_reset_midstream done");
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_redir: valid=%b addr=%h, want 0 fffffffc", inst_valid, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'hECA8_6423 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_top: valid=%b pc=%h data=%h addr=%h, want 1 fffffffc eca86423 00000000",
               inst_valid, inst_pc, inst_data, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0050_0093) begin
      errors++;
      $display("FAIL wrap_zero: valid=%b pc=%h data=%h, want 1 00000000 00500093", inst_valid, inst_pc, inst_data);
    end
    // Redirect together with fetch_en falling: redirect wins, block goes idle.
    inst_ready = 1'b0;
    step();
    fetch_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0010;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL redir_stop: valid=%b busy=%b addr=%h, want 0 0 00000010", inst_valid, busy, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL redir_stop_hold: valid=%b busy=%b addr=%h, want 0 0 00000010", inst_valid, busy, imem_addr);
    end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_drain();
    test_reset_midstream();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
